// File: rtl/rom_stream_reader.sv
// Walks a contiguous ROM address window and streams each word on a valid/ready port with a last marker.
// Optional running checksum output io_csum is enabled by defining ROM_STREAM_CSUM_EN.
module rom_stream_reader #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_start,
  input  logic [ADDR_W-1:0] io_base,
  input  logic [LEN_W-1:0]  io_len,
  output logic              io_busy,
  output logic [ADDR_W-1:0] io_rom_addr,
  input  logic [DATA_W-1:0] io_rom_data,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [DATA_W-1:0] io_out_bits,
  output logic              io_out_last,
  output logic              io_done
`ifdef ROM_STREAM_CSUM_EN
  ,
  output logic [DATA_W-1:0] io_csum
`endif
);

  localparam int               DEPTH   = 1 << ADDR_W;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [DATA_W-1:0]   bits_q, bits_d;
  logic                last_q, last_d;
  logic [LEN_W-1:0]    len_clamped;
  logic                capture;
  logic                handshake;
`ifdef ROM_STREAM_CSUM_EN
  logic [DATA_W-1:0]   csum_q, csum_d;
`endif

  // Out-of-range lengths are treated as a full sweep of the ROM.
  assign len_clamped = (io_len > MAX_LEN) ? MAX_LEN : io_len;
  assign handshake   = (state_q == S_SEND) && io_out_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    bits_d  = bits_q;
    last_d  = last_q;
    capture = 1'b0;
`ifdef ROM_STREAM_CSUM_EN
    csum_d  = csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (io_start) begin
`ifdef ROM_STREAM_CSUM_EN
          csum_d = '0;
`endif
          if (len_clamped == '0) begin
            state_d = S_DONE;
          end else begin
            addr_d  = io_base;
            rem_d   = len_clamped;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        capture = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (handshake) begin
`ifdef ROM_STREAM_CSUM_EN
          csum_d = csum_q + bits_q;
`endif
          if (last_q) begin
            state_d = S_DONE;
          end else begin
            capture = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The same word/counter update serves both the first fetch and back-to-back beats.
    if (capture) begin
      bits_d = io_rom_data;
      last_d = (rem_q == LEN_W'(1));
      addr_d = addr_q + ADDR_W'(1);
      rem_d  = rem_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      bits_q  <= '0;
      last_q  <= 1'b0;
`ifdef ROM_STREAM_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      bits_q  <= bits_d;
      last_q  <= last_d;
`ifdef ROM_STREAM_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign io_busy      = (state_q != S_IDLE);
  assign io_out_valid = (state_q == S_SEND);
  assign io_done      = (state_q == S_DONE);
  assign io_rom_addr  = addr_q;
  assign io_out_bits  = bits_q;
  assign io_out_last  = last_q;
`ifdef ROM_STREAM_CSUM_EN
  assign io_csum      = csum_q;
`endif

endmodule
